// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit UART transmitter among NREQ level requesters.
// Optional WAIT_DONE watchdog and tx_err port are enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int BUSY_WAIT = 16
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 2**20
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [31:0]          tx_dato,
  output logic                 tx_start,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                 tx_err,
`endif
  input  logic                 tx_listo
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
`else
  localparam int CNT_MAX = BUSY_WAIT;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACK} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, pick;
  logic            found;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     dato_q, dato_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     slot [NREQ];
`ifdef UART_ARB_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot[g] = req_data[32*g +: 32];
  end

  // Scan from the highest offset down so the request nearest ptr wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[PW'((int'(ptr_q) + i) % NREQ)]) begin
        pick  = PW'((int'(ptr_q) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    dato_d  = dato_q;
    cnt_d   = cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && tx_listo) begin
          win_d   = pick;
          grant_d = NREQ'(1) << pick;
          dato_d  = slot[pick];
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_listo) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          // Transmitter never went busy: the start pulse was missed, re-issue it.
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
        if (tx_listo) begin
          grant_d = '0;
          state_d = ACK;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      dato_q  <= '0;
      cnt_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      dato_q  <= dato_d;
      cnt_q   <= cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign tx_dato  = dato_q;
  assign busy     = (state_q != IDLE);
  assign tx_start = (state_q == START);
  assign ack      = (state_q == ACK) ? (NREQ'(1) << win_q) : '0;
`ifdef UART_ARB_TIMEOUT_EN
  assign tx_err   = (state_q == ACK) && err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter is modelled by driving tx_listo by hand.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant, ack;
  logic              busy, tx_start, tx_listo;
  logic [31:0]       tx_dato;
`ifdef UART_ARB_TIMEOUT_EN
  logic              tx_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  uart_tx_arbiter #(
    .NREQ(NREQ), .BUSY_WAIT(BW)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .busy(busy), .tx_dato(tx_dato),
    .tx_start(tx_start),
`ifdef UART_ARB_TIMEOUT_EN
    .tx_err(tx_err),
`endif
    .tx_listo(tx_listo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called with the DUT in IDLE and the winning req already visible to the next edge.
  task automatic xfer(input logic [31:0] d, input logic [NREQ-1:0] g, input int gap,
                      input bit drop, input int miss);
    int acks;
    tick();
    chk("start", 32'(tx_start), 32'd1);
    chk("dato", tx_dato, d);
    chk("grant", 32'(grant), 32'(g));
    chk("busy", 32'(busy), 32'd1);
    if (drop) req = '0;
    for (int m = 0; m < miss; m++) begin
      acks = 0;
      repeat (BW) begin
        tick();
        if (tx_start) acks++;
      end
      chk("nostart_bw", 32'(acks), 32'd0);
      tick();
      chk("restart", 32'(tx_start), 32'd1);
      chk("restart_dato", tx_dato, d);
    end
    tick();
    chk("start_1cyc", 32'(tx_start), 32'd0);
    tx_listo = 1'b0;
    acks = 0;
    repeat (gap) begin
      tick();
      if (ack != '0 || tx_start) acks++;
    end
    chk("no_early_ack", 32'(acks), 32'd0);
    chk("grant_hold", 32'(grant), 32'(g));
    chk("dato_hold", tx_dato, d);
    tx_listo = 1'b1;
    tick();
    chk("ack", 32'(ack), 32'(g));
    chk("grant_clr", 32'(grant), 32'd0);
    tick();
    chk("ack_1cyc", 32'(ack), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; tx_listo = 1'b1;
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dato", tx_dato, 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);

    // single requester, long transfer
    reset = 1'b0;
    req_data[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    xfer(32'hDEADBEEF, 4'b0001, 40, 1'b0, 0);
    req = '0;

    // all requesters held: full round then wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h11111111 * (i + 1);
    req = 4'b1111;
    xfer(32'h11111111, 4'b0001, 3, 1'b0, 0);
    xfer(32'h22222222, 4'b0010, 3, 1'b0, 0);
    xfer(32'h33333333, 4'b0100, 3, 1'b0, 0);
    xfer(32'h44444444, 4'b1000, 3, 1'b0, 0);
    xfer(32'h11111111, 4'b0001, 3, 1'b0, 0);
    req = '0;

    // serve 2, then 0101 together: pointer wraps to 0 first
    req = 4'b0100;
    xfer(32'h33333333, 4'b0100, 2, 1'b0, 0);
    req = 4'b0101;
    xfer(32'h11111111, 4'b0001, 2, 1'b0, 0);
    xfer(32'h33333333, 4'b0100, 2, 1'b0, 0);
    req = '0;

    // transmitter busy at request time; requester drops req while granted
    tx_listo = 1'b0;
    req_data[63:32] = 32'hCAFEF00D;
    req = 4'b0010;
    cnt = 0;
    repeat (10) begin
      tick();
      if (tx_start || busy) cnt++;
    end
    chk("wait_listo", 32'(cnt), 32'd0);
    tx_listo = 1'b1;
    xfer(32'hCAFEF00D, 4'b0010, 5, 1'b1, 0);
    tick();
    chk("no_reserve", 32'(busy), 32'd0);

    // first start pulse ignored by the transmitter
    req_data[127:96] = 32'h0BADF00D;
    req = 4'b1000;
    xfer(32'h0BADF00D, 4'b1000, 4, 1'b1, 1);

    // reset during WAIT_DONE abandons the word
    req_data[31:0] = 32'h12345678;
    req = 4'b0001;
    tick();
    chk("r6_start", 32'(tx_start), 32'd1);
    tick();
    tx_listo = 1'b0;
    repeat (3) tick();
    chk("r6_busy", 32'(busy), 32'd1);
    chk("r6_grant", 32'(grant), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("r6_grant0", 32'(grant), 32'd0);
    chk("r6_busy0", 32'(busy), 32'd0);
    chk("r6_dato0", tx_dato, 32'd0);
    tx_listo = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (ack != '0 || busy) cnt++;
    end
    chk("r6_noack", 32'(cnt), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
    // stuck transmitter: ack and tx_err on cycle 101 of WAIT_DONE
    req = 4'b0001;
    tick();
    chk("to_start", 32'(tx_start), 32'd1);
    req = '0;
    tick();
    tx_listo = 1'b0;
    tick();
    cnt = 0;
    repeat (99) begin
      tick();
      if (ack != '0 || tx_err) cnt++;
    end
    chk("to_early", 32'(cnt), 32'd0);
    tick();
    chk("to_ack", 32'(ack), 32'd1);
    chk("to_err", 32'(tx_err), 32'd1);
    tick();
    chk("to_err_1cyc", 32'(tx_err), 32'd0);
    tx_listo = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
